// File: rtl/wfg_uart_wb_master.sv
// UART (8N1) to Wishbone classic bridge master: framed 'W'/'R' commands in, 'K'/'E' status
// plus read data out. Single outstanding bus cycle, half-duplex framing.
module wfg_uart_wb_master #(
  parameter int BUSW          = 32,
  parameter int CLKS_PER_BIT  = 217,
  parameter int ACK_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 250000
) (
  input  logic            io_wbs_clk,
  input  logic            io_wbs_rst_n,
  input  logic            uart_rx_i,
  output logic            uart_tx_o,
  output logic [BUSW-1:0] wbm_adr_o,
  output logic [BUSW-1:0] wbm_datwr_o,
  input  logic [BUSW-1:0] wbm_datrd_i,
  output logic            wbm_we_o,
  output logic            wbm_stb_o,
  output logic            wbm_cyc_o,
  input  logic            wbm_ack_i,
  output logic            busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW-1:0] ACK_END  = AW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(FRAME_TIMEOUT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_e;

  rx_state_e rx_st_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q, rx_valid_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;

  // RX sampler runs in every parser state so it never loses bit alignment
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
          rx_st_q  <= RX_START;
          rx_cnt_q <= '0;
        end
        RX_START: if (rx_cnt_q == HALF_END) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_DATA: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        default: if (rx_cnt_q == BIT_END) begin
          rx_cnt_q   <= '0;
          rx_valid_q <= rx_sync_q;
          rx_st_q    <= RX_IDLE;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
      endcase
    end
  end

  state_e state_q, state_d;
  logic            we_q, we_d, cyc_q, cyc_d, ok_q, ok_d, tx_q, tx_d;
  logic [BUSW-1:0] adr_q, adr_d, datwr_q, datwr_d, rd_q, rd_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [2:0]      tx_idx_q, tx_idx_d, tx_last;
  logic [7:0]      tx_byte;
  logic [9:0]      tx_frame;

  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      ok_q       <= 1'b0;
      tx_q       <= 1'b1;
      adr_q      <= '0;
      datwr_q    <= '0;
      rd_q       <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      ack_cnt_q  <= '0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      ok_q       <= ok_d;
      tx_q       <= tx_d;
      adr_q      <= adr_d;
      datwr_q    <= datwr_d;
      rd_q       <= rd_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      ack_cnt_q  <= ack_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_idx_q   <= tx_idx_d;
    end
  end

  // Response byte 0 is the status, bytes 1..4 the captured read word MSB first
  always_comb begin
    case (tx_idx_q)
      3'd0:    tx_byte = ok_q ? 8'h4B : 8'h45;
      3'd1:    tx_byte = rd_q[31:24];
      3'd2:    tx_byte = rd_q[23:16];
      3'd3:    tx_byte = rd_q[15:8];
      default: tx_byte = rd_q[7:0];
    endcase
    tx_frame = {1'b1, tx_byte, 1'b0};
    tx_last  = (ok_q && !we_q) ? 3'd4 : 3'd0;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    ok_d       = ok_q;
    adr_d      = adr_q;
    datwr_d    = datwr_q;
    rd_d       = rd_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    ack_cnt_d  = ack_cnt_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_idx_d   = tx_idx_q;
    tx_d       = (state_q == S_RESP) ? tx_frame[tx_bit_q] : 1'b1;
    case (state_q)
      S_IDLE: if (rx_valid_q && (rx_shift_q == 8'h57 || rx_shift_q == 8'h52)) begin
        we_d       = (rx_shift_q == 8'h57);
        state_d    = S_ADDR;
        byte_cnt_d = '0;
        gap_d      = '0;
      end
      S_ADDR, S_DATA: begin
        if (rx_valid_q) begin
          gap_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_ADDR) adr_d = {adr_q[BUSW-9:0], rx_shift_q};
          else                   datwr_d = {datwr_q[BUSW-9:0], rx_shift_q};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_ADDR && we_q) begin
              state_d = S_DATA;
            end else begin
              state_d   = S_BUS;
              cyc_d     = 1'b1;
              ack_cnt_d = '0;
            end
          end
        end else if (gap_q == GAP_END) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_BUS: begin
        if (wbm_ack_i || ack_cnt_q == ACK_END) begin
          cyc_d    = 1'b0;
          ok_d     = wbm_ack_i;
          state_d  = S_RESP;
          tx_cnt_d = '0;
          tx_bit_d = '0;
          tx_idx_d = '0;
          if (wbm_ack_i) rd_d = wbm_datrd_i;
        end else begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
      end
      S_RESP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = '0;
            if (tx_idx_q == tx_last) state_d = S_IDLE;
            else                     tx_idx_d = tx_idx_q + 3'd1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign uart_tx_o   = tx_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_datwr_o = datwr_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = cyc_q & we_q;
  assign busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_wfg_uart_wb_master.sv
// Scoreboard bench for wfg_uart_wb_master: stimulus pushes expected bus cycles and TX bytes,
// independent monitors pop and compare as the DUT produces them.
module tb_wfg_uart_wb_master;
  localparam int CPB = 8;
  localparam int ACK_TO = 1024;
  localparam int FRAME_TO = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [31:0] adr, datwr;
  logic [31:0] datrd = '0;
  logic        we, stb, cyc, busy;
  logic        ack = 1'b0;

  wfg_uart_wb_master #(
    .BUSW(32), .CLKS_PER_BIT(CPB), .ACK_TIMEOUT(ACK_TO), .FRAME_TIMEOUT(FRAME_TO)
  ) dut (
    .io_wbs_clk(clk), .io_wbs_rst_n(rst_n), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx),
    .wbm_adr_o(adr), .wbm_datwr_o(datwr), .wbm_datrd_i(datrd), .wbm_we_o(we),
    .wbm_stb_o(stb), .wbm_cyc_o(cyc), .wbm_ack_i(ack), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  int n_chk = 0;
  int n_fail = 0;
  int we_viol = 0;
  int ack_delay = -1;
  logic [31:0] rd_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Wishbone slave: acks after ack_delay wait cycles, never when ack_delay < 0
  int wcnt = 0;
  always @(negedge clk) begin
    if (cyc && stb && !ack && ack_delay >= 0) begin
      if (wcnt == ack_delay) begin
        ack   = 1'b1;
        datrd = rd_data;
      end else wcnt++;
    end else begin
      ack  = 1'b0;
      wcnt = 0;
    end
  end

  // Bus monitor
  initial begin
    bit          in_cyc = 0;
    bit          stable = 1;
    int          len = 0;
    bus_t        e;
    logic [31:0] a0, d0;
    logic        w0;
    forever begin
      @(negedge clk);
      if (!cyc && we) we_viol++;
      if (cyc && !in_cyc) begin
        in_cyc = 1; len = 1; stable = 1;
        a0 = adr; d0 = datwr; w0 = we;
        if (exp_bus.size() == 0) begin
          fail_now("unexpected_bus_cycle");
          e = '{adr: adr, dat: datwr, we: we, len: -1};
        end else begin
          e = exp_bus.pop_front();
          chk("bus_adr", adr, e.adr);
          chk("bus_we", {31'b0, we}, {31'b0, e.we});
          if (e.we) chk("bus_datwr", datwr, e.dat);
        end
      end else if (cyc) begin
        len++;
        if (adr !== a0 || datwr !== d0 || we !== w0) stable = 0;
      end else if (in_cyc) begin
        in_cyc = 0;
        if (e.len >= 0) chk("bus_cyc_len", len, e.len);
        chk("bus_stable", {31'b0, stable}, 32'd1);
      end
    end
  end

  // UART TX monitor
  initial begin
    logic [7:0] b;
    logic       stopb;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
          end
          repeat (CPB) @(negedge clk);
          stopb = uart_tx;
          if (exp_tx.size() == 0) begin
            fail_now($sformatf("unexpected_tx_byte got 0x%02h", b));
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", {24'b0, b}, {24'b0, e});
            chk("tx_stop", {31'b0, stopb}, 32'd1);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'b0, busy}, 32'd0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int dly);
    ack_delay = dly;
    exp_bus.push_back('{adr: a, dat: d, we: 1'b1, len: dly + 1});
    exp_tx.push_back(8'h4B);
    send_byte(8'h57);
    send_word(a);
    send_word(d);
    wait_idle("idle_after_write");
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int dly);
    ack_delay = dly;
    rd_data   = d;
    if (dly < 0) begin
      exp_bus.push_back('{adr: a, dat: 32'h0, we: 1'b0, len: ACK_TO});
      exp_tx.push_back(8'h45);
    end else begin
      exp_bus.push_back('{adr: a, dat: 32'h0, we: 1'b0, len: dly + 1});
      exp_tx.push_back(8'h4B);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(d[8*i +: 8]);
    end
    send_byte(8'h52);
    send_word(a);
    wait_idle("idle_after_read");
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_stb", {31'b0, stb}, 32'd0);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_datwr", datwr, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    // 1 write
    do_write(32'h0000_0004, 32'h1234_5678, 2);
    // 2 read
    do_read(32'h0000_0008, 32'hCAFE_F00D, 1);
    // 3 ack timeout
    do_read(32'h0000_0010, 32'h0, -1);

    // 4 garbage then partial frame abandoned by gap timeout
    send_byte(8'h00);
    chk("busy_after_garbage", {31'b0, busy}, 32'd0);
    send_byte(8'h57);
    chk("busy_after_cmd", {31'b0, busy}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (1000) @(negedge clk);
    chk("busy_after_gap", {31'b0, busy}, 32'd0);
    do_write(32'h0000_0020, 32'hA5A5_5A5A, 0);

    // 5 framing error on a command byte
    send_byte(8'h57, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("busy_after_frame_err", {31'b0, busy}, 32'd0);
    do_read(32'h0000_000C, 32'h0123_4567, 3);

    // 6 reset in the middle of a bus cycle
    ack_delay = -1;
    exp_bus.push_back('{adr: 32'h30, dat: 32'hDEAD_BEEF, we: 1'b1, len: -1});
    send_byte(8'h57);
    send_word(32'h0000_0030);
    send_word(32'hDEAD_BEEF);
    n = 0;
    while (!cyc && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cyc_before_reset", {31'b0, cyc}, 32'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'b0, cyc}, 32'd0);
    chk("arst_stb", {31'b0, stb}, 32'd0);
    chk("arst_we", {31'b0, we}, 32'd0);
    chk("arst_tx", {31'b0, uart_tx}, 32'd1);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    do_read(32'h0000_0040, 32'h89AB_CDEF, 2);
    do_write(32'h0000_0044, 32'h0BAD_F00D, 1);

    repeat (4 * CPB) @(negedge clk);
    chk("bus_queue_empty", exp_bus.size(), 32'd0);
    chk("tx_queue_empty", exp_tx.size(), 32'd0);
    chk("we_low_without_cyc", we_viol, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
